uart_wb_master: RTL and testbench
=================================

// Module: uart_wb_master
// PURPOSE
// - Host command bridge. Turns a byte stream from the board UART receiver into single 8-bit Wishbone pipelined transactions.
// - Drives the core's Wishbone slave port (CYC/STB/WE/ADDR/WDATA/SEL; STALL/ACK/RDATA/ERR).
// - Returns status and read data as a byte stream to the UART transmitter.
// PARAMETERS
// - ADDR_WIDTH   32       Wishbone address width; always sent as 4 bytes, MSB first.
// - TIMEOUT_CYC  1024     Max cycles CYC may stay high before the transfer is aborted; >=4.
// PORTS
// - CLK          in   1           clock
// - rstn         in   1           reset, synchronous, active-low
// - rx_data      in   8           command byte from UART RX
// - rx_valid     in   1           rx_data valid
// - rx_ready     out  1           byte accepted when rx_valid & rx_ready
// - tx_data      out  8           response byte to UART TX
// - tx_valid     out  1           tx_data valid; held stable until accepted
// - tx_ready     in   1           TX accepts when tx_valid & tx_ready
// - wb_cyc       out  1           Wishbone CYC
// - wb_stb       out  1           Wishbone STB
// - wb_we        out  1           1 = write
// - wb_addr      out  ADDR_WIDTH  byte address
// - wb_wdata     out  8           write data
// - wb_sel       out  1           always 1 while wb_stb is high, else 0
// - wb_stall     in   1           slave cannot accept STB this cycle
// - wb_ack       in   1           transfer done OK
// - wb_rdata     in   8           read data, valid with wb_ack
// - wb_err       in   1           transfer done with error
// BEHAVIOUR
// - Reset values: rx_ready=0, tx_valid=0, tx_data=0, wb_cyc=0, wb_stb=0, wb_we=0, wb_addr=0, wb_wdata=0, wb_sel=0. FSM goes to IDLE.
// - Protocol:
//   - write: 0x57 'W', A3, A2, A1, A0, D. Reply: status byte.
//   - read: 0x52 'R', A3..A0. Reply: status byte, then data byte only if status = 0x4B.
// - Status codes: 0x4B 'K' ok; 0x45 'E' wb_err; 0x54 'T' timeout; 0x3F '?' bad opcode.
// - FSM states: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_STAT, RESP_DATA.
// - rx_ready=1 only in IDLE, ADDR and DATA. It is registered and goes high the cycle after the state is entered.
// - IDLE: accept opcode.
//   - 'W' or 'R' -> ADDR, byte counter cleared.
//   - Any other byte -> RESP_STAT with status '?'.
// - ADDR: shift in 4 bytes. After the 4th: -> DATA if write, -> BUS_REQ if read.
// - DATA: latch wb_wdata -> BUS_REQ.
// - BUS_REQ: wb_cyc, wb_stb, wb_sel assert the cycle after the last command byte is accepted.
//   - wb_stb stays high while wb_stall=1.
//   - First cycle with wb_stall=0 is the accept cycle; wb_stb drops the next cycle -> BUS_WAIT.
//   - ack or err in the accept cycle is legal and completes the transfer directly.
// - BUS_WAIT: wb_cyc stays high until wb_ack or wb_err.
//   - Capture wb_rdata on ack. Status 'K' on ack, 'E' on err.
//   - wb_cyc drops the next cycle -> RESP_STAT.
//   - ack and err together: err wins.
//   - ack/err while wb_cyc=0 is ignored.
// - Timeout: counter clears on entry to BUS_REQ and counts every cycle wb_cyc=1.
//   - On reaching TIMEOUT_CYC: wb_cyc=wb_stb=0 the next cycle, status 'T' -> RESP_STAT.
//   - Completion and timeout in the same cycle: completion wins.
// - RESP_STAT: tx_valid=1 with status, held until tx_ready.
//   - -> RESP_DATA if read and 'K'; otherwise -> IDLE.
// - RESP_DATA: send captured data byte -> IDLE.
// - Minimum latency: 1 cycle from last command byte to wb_stb. With no stall and ack in the accept cycle, 2 cycles from ack to tx_valid.
// - wb_addr, wb_we, wb_wdata are stable for the whole time wb_cyc=1.
// - Reset mid-transfer: all outputs return to reset values the next cycle. The partial command is discarded and no reply is sent.
// STRUCTURE
// - Shared package uart_wb_pkg:
//   - OPC_WRITE=8'h57, OPC_READ=8'h52
//   - ST_OK=8'h4B, ST_ERR=8'h45, ST_TMO=8'h54, ST_BAD=8'h3F
//   - state enum encoding
// - One sub-module, wb_timeout_cnt: clear, enable, terminal-count flag, width clog2(TIMEOUT_CYC+1).
// - Everything else stays in one FSM plus datapath registers.
// TESTING
// - Write, no stall: 57 30 00 00 10 A5 -> one STB, we=1, addr=0x3000_0010, wdata=A5; ack next cycle -> tx 4B.
// - Read with stall: 52 30 00 00 20 and stall held 3 cycles -> stb high for exactly 4 cycles; ack with rdata=3C -> tx 4B, 3C.
// - Bus error: read with wb_err -> tx 45 only, no data byte; wb_cyc low one cycle after err.
// - Timeout: no ack, TIMEOUT_CYC=16 -> cyc drops after 16 cycles, tx 54; a late ack afterwards is ignored and the next command works.
// - Bad opcode and backpressure: rx 41 -> tx 3F; tx_ready low 5 cycles -> tx_valid/tx_data held stable, rx_ready=0 meanwhile.
// - Reset mid-command: rstn low after 57 30 00 -> all outputs at reset values the next cycle; a full write afterwards completes with 4B.

Source files
------------

// File: rtl/uart_wb_pkg.sv
// Shared constants and FSM encoding for the UART-to-Wishbone command bridge.
package uart_wb_pkg;

    // Command opcodes received from the host
    localparam logic [7:0] OPC_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] OPC_READ  = 8'h52;  // 'R'

    // Status bytes returned to the host
    localparam logic [7:0] ST_OK  = 8'h4B;     // 'K'
    localparam logic [7:0] ST_ERR = 8'h45;     // 'E'
    localparam logic [7:0] ST_TMO = 8'h54;     // 'T'
    localparam logic [7:0] ST_BAD = 8'h3F;     // '?'

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_DATA      = 3'd2,
        S_BUS_REQ   = 3'd3,
        S_BUS_WAIT  = 3'd4,
        S_RESP_STAT = 3'd5,
        S_RESP_DATA = 3'd6
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OPC_WRITE) || (b == OPC_READ);
    endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Wishbone pipelined single-master bus (8-bit data, one select bit).
interface uart_wb_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            wdata;
    logic                  sel;
    logic                  stall;
    logic                  ack;
    logic [7:0]            rdata;
    logic                  err;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, rdata, err
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, rdata, err
    );
endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts cycles while enabled, flags the cycle in which
// the count reaches TIMEOUT_CYC so the owner can drop CYC on the next edge.
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic CLK,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int            W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
    localparam logic [W-1:0] TERM = W'(TIMEOUT_CYC);

    logic [W-1:0] cnt;

    // Clear has priority; count saturates so it can never wrap back to zero.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + W'(1);
        end
    end

    // Asserted during the TIMEOUT_CYC-th enabled cycle.
    assign tc = en && (cnt == LAST);
endmodule

// File: rtl/uart_wb_master.sv
// Host command bridge: UART byte stream -> single 8-bit Wishbone transfers,
// status and read data returned as a UART byte stream.
//
// Handshakes: a byte moves on rx (or tx) at a rising edge where valid and
// ready are both high; the sender keeps valid and data stable until then,
// and the receiver may toggle ready freely.
module uart_wb_master
    import uart_wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,  // at most 32: always sent as 4 bytes
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    CLK,
    input  logic                    rstn,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    uart_wb_master_if.master        wb,
    output state_t                  dbg_state
);

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           addr_hi;
    logic [31:0]           addr_next;
    logic [7:0]            status;
    logic [7:0]            rdata_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic                  sel_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            wdata_q;
    logic                  rx_fire;
    logic                  tmo;

    assign rx_fire   = rx_valid && rx_ready;
    assign addr_next = {addr_hi, rx_data};
    assign dbg_state = state;

    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = we_q;
    assign wb.sel   = sel_q;
    assign wb.addr  = addr_q;
    assign wb.wdata = wdata_q;

    // Watchdog runs only while CYC is high and is held clear otherwise,
    // so every bus transfer starts from zero.
    wb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .CLK  (CLK),
        .rstn (rstn),
        .clr  (!cyc_q),
        .en   (cyc_q),
        .tc   (tmo)
    );

    // Command parser, bus sequencer and response sender with registered outputs.
    always_ff @(posedge CLK) begin
        if (!rstn) begin
            state    <= S_IDLE;
            byte_cnt <= 2'd0;
            addr_hi  <= '0;
            status   <= ST_OK;
            rdata_q  <= 8'h00;
            rx_ready <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        if (is_opcode(rx_data)) begin
                            we_q     <= (rx_data == OPC_WRITE);
                            byte_cnt <= 2'd0;
                            state    <= S_ADDR;
                        end else begin
                            status   <= ST_BAD;
                            rx_ready <= 1'b0;
                            state    <= S_RESP_STAT;
                        end
                    end
                end

                S_ADDR: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        addr_hi  <= addr_next[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            addr_q <= ADDR_WIDTH'(addr_next);
                            if (we_q) begin
                                state <= S_DATA;
                            end else begin
                                // Read: launch the bus cycle straight away
                                rx_ready <= 1'b0;
                                cyc_q    <= 1'b1;
                                stb_q    <= 1'b1;
                                sel_q    <= 1'b1;
                                state    <= S_BUS_REQ;
                            end
                        end
                    end
                end

                S_DATA: begin
                    rx_ready <= 1'b1;
                    if (rx_fire) begin
                        wdata_q  <= rx_data;
                        rx_ready <= 1'b0;
                        cyc_q    <= 1'b1;
                        stb_q    <= 1'b1;
                        sel_q    <= 1'b1;
                        state    <= S_BUS_REQ;
                    end
                end

                S_BUS_REQ: begin
                    // Only the non-stalled (accept) cycle can complete the
                    // transfer; completion outranks the watchdog.
                    if (!wb.stall) begin
                        stb_q <= 1'b0;
                        sel_q <= 1'b0;
                        if (wb.err) begin
                            status <= ST_ERR;
                            cyc_q  <= 1'b0;
                            state  <= S_RESP_STAT;
                        end else if (wb.ack) begin
                            status  <= ST_OK;
                            rdata_q <= wb.rdata;
                            cyc_q   <= 1'b0;
                            state   <= S_RESP_STAT;
                        end else if (tmo) begin
                            status <= ST_TMO;
                            cyc_q  <= 1'b0;
                            state  <= S_RESP_STAT;
                        end else begin
                            state <= S_BUS_WAIT;
                        end
                    end else if (tmo) begin
                        stb_q  <= 1'b0;
                        sel_q  <= 1'b0;
                        cyc_q  <= 1'b0;
                        status <= ST_TMO;
                        state  <= S_RESP_STAT;
                    end
                end

                S_BUS_WAIT: begin
                    if (wb.err) begin
                        status <= ST_ERR;
                        cyc_q  <= 1'b0;
                        state  <= S_RESP_STAT;
                    end else if (wb.ack) begin
                        status  <= ST_OK;
                        rdata_q <= wb.rdata;
                        cyc_q   <= 1'b0;
                        state   <= S_RESP_STAT;
                    end else if (tmo) begin
                        status <= ST_TMO;
                        cyc_q  <= 1'b0;
                        state  <= S_RESP_STAT;
                    end
                end

                S_RESP_STAT: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= status;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (!we_q && (status == ST_OK)) begin
                            state <= S_RESP_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_RESP_DATA: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rdata_q;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: table of complete commands plus
// hand-written sequences for latency, late ack, backpressure and reset.
module tb_uart_wb_master;
    import uart_wb_pkg::*;

    localparam int TMO    = 16;
    localparam int WINDOW = 50;
    localparam int NVEC   = 10;

    logic       CLK = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    state_t     dbg_state;

    int tests = 0;
    int fails = 0;

    uart_wb_master_if #(.ADDR_WIDTH(32)) bus ();

    uart_wb_master #(.ADDR_WIDTH(32), .TIMEOUT_CYC(TMO)) dut (
        .CLK       (CLK),
        .rstn      (rstn),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .wb        (bus),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // resp: 0 ack in accept cycle, 1 ack next cycle, 2 err next cycle, 3 never
    typedef struct packed {
        int               n;
        logic [0:5][7:0]  cmd;
        int               stall;
        int               resp;
        logic [7:0]       rdata;
        int               exp_stb;
        int               exp_cyc;
        logic             exp_we;
        logic [31:0]      exp_addr;
        logic [7:0]       exp_wdata;
        int               exp_ntx;
        logic [0:1][7:0]  exp_tx;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input int n, input logic [47:0] cmd, input int stall,
                                input int resp, input logic [7:0] rdata, input int e_stb,
                                input int e_cyc, input logic e_we, input logic [31:0] e_addr,
                                input logic [7:0] e_wdata, input int e_ntx,
                                input logic [15:0] e_tx);
        vec_t v;
        v.n = n; v.cmd = cmd; v.stall = stall; v.resp = resp; v.rdata = rdata;
        v.exp_stb = e_stb; v.exp_cyc = e_cyc; v.exp_we = e_we; v.exp_addr = e_addr;
        v.exp_wdata = e_wdata; v.exp_ntx = e_ntx; v.exp_tx = e_tx;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 20; k++) begin
            if (rx_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        rx_valid = 1'b0;
        check($sformatf("rx accept %0h", b), 64'(ok), 64'd1);
    endtask

    task automatic recv_byte(input string name, input logic [7:0] exp);
        bit         got = 0;
        logic [7:0] b = 8'h00;
        tx_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tx_valid) begin
                b   = tx_data;
                got = 1;
                step();
                break;
            end
            step();
        end
        tx_ready = 1'b0;
        check({name, " seen"}, 64'(got), 64'd1);
        check(name, 64'(b), 64'(exp));
    endtask

    task automatic bus_idle_inputs();
        bus.stall = 1'b0;
        bus.ack   = 1'b0;
        bus.err   = 1'b0;
    endtask

    // Runs one command for a fixed window, acting as both UART peer and bus slave.
    task automatic run_txn(input vec_t v, input int id);
        int          idx = 0;
        int          stall_left = v.stall;
        int          stb_cnt = 0;
        int          cyc_cnt = 0;
        int          ntx = 0;
        bit          accepted = 0;
        bit          acked = 0;
        bit          seen = 0;
        bit          unstable = 0;
        bit          accept_rx;
        bit          stb_acc;
        logic [31:0] a0 = '0;
        logic        a_we = 1'b0;
        logic [7:0]  a_wd = 8'h00;
        logic [7:0]  txb [4];
        for (int i = 0; i < 4; i++) txb[i] = 8'h00;
        tx_ready  = 1'b1;
        bus.rdata = v.rdata;
        for (int c = 0; c < WINDOW; c++) begin
            rx_valid  = (idx < v.n);
            rx_data   = (idx < v.n) ? v.cmd[idx] : 8'h00;
            accept_rx = rx_valid && rx_ready;
            bus.stall = bus.stb && (stall_left > 0);
            bus.ack   = 1'b0;
            bus.err   = 1'b0;
            if (bus.cyc && !acked) begin
                if (v.resp == 0 && bus.stb && !bus.stall) bus.ack = 1'b1;
                else if (v.resp == 1 && accepted)        bus.ack = 1'b1;
                else if (v.resp == 2 && accepted)        bus.err = 1'b1;
            end
            stb_acc = bus.stb && !bus.stall;
            if (bus.cyc) begin
                cyc_cnt++;
                if (!seen) begin
                    seen = 1; a0 = bus.addr; a_we = bus.we; a_wd = bus.wdata;
                end else if (bus.addr !== a0 || bus.we !== a_we || bus.wdata !== a_wd) begin
                    unstable = 1;
                end
            end
            if (bus.stb) stb_cnt++;
            if (tx_valid && tx_ready) begin
                if (ntx < 4) txb[ntx] = tx_data;
                ntx++;
            end
            step();
            if (accept_rx) idx++;
            if (bus.stall) stall_left--;
            if (stb_acc) accepted = 1;
            if (bus.ack || bus.err) acked = 1;
        end
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        bus_idle_inputs();
        check($sformatf("v%0d cmd bytes taken", id), 64'(idx), 64'(v.n));
        check($sformatf("v%0d tx count", id), 64'(ntx), 64'(v.exp_ntx));
        for (int i = 0; i < v.exp_ntx; i++)
            check($sformatf("v%0d tx byte %0d", id, i), 64'(txb[i]), 64'(v.exp_tx[i]));
        check($sformatf("v%0d stb cycles", id), 64'(stb_cnt), 64'(v.exp_stb));
        check($sformatf("v%0d cyc cycles", id), 64'(cyc_cnt), 64'(v.exp_cyc));
        if (v.exp_cyc > 0) begin
            check($sformatf("v%0d addr", id), 64'(a0), 64'(v.exp_addr));
            check($sformatf("v%0d we", id), 64'(a_we), 64'(v.exp_we));
            check($sformatf("v%0d bus stable", id), 64'(unstable), 64'd0);
            if (v.exp_we)
                check($sformatf("v%0d wdata", id), 64'(a_wd), 64'(v.exp_wdata));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {rx_ready, tx_valid, tx_data, bus.cyc, bus.stb, bus.we,
                     bus.addr, bus.wdata, bus.sel}, 64'd0);
        check({name, " state"}, 64'(dbg_state), 64'(S_IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit bad;

        //            n  cmd                  stall resp rdata stb cyc we addr          wd     ntx tx
        vecs[0] = mk(6, 48'h57_30_00_00_10_A5, 0,  1, 8'h00, 1,  2,  1, 32'h3000_0010, 8'hA5, 1, 16'h4B00);
        vecs[1] = mk(5, 48'h52_30_00_00_20_00, 3,  1, 8'h3C, 4,  5,  0, 32'h3000_0020, 8'h00, 2, 16'h4B3C);
        vecs[2] = mk(5, 48'h52_12_34_56_78_00, 0,  2, 8'h5A, 1,  2,  0, 32'h1234_5678, 8'h00, 1, 16'h4500);
        vecs[3] = mk(5, 48'h52_00_00_00_01_00, 0,  0, 8'h99, 1,  1,  0, 32'h0000_0001, 8'h00, 2, 16'h4B99);
        vecs[4] = mk(6, 48'h57_DE_AD_BE_EF_5A, 2,  0, 8'h00, 3,  3,  1, 32'hDEAD_BEEF, 8'h5A, 1, 16'h4B00);
        vecs[5] = mk(6, 48'h57_00_00_00_FF_00, 1,  2, 8'h00, 2,  3,  1, 32'h0000_00FF, 8'h00, 1, 16'h4500);
        vecs[6] = mk(1, 48'h41_00_00_00_00_00, 0,  3, 8'h00, 0,  0,  0, 32'h0,         8'h00, 1, 16'h3F00);
        vecs[7] = mk(1, 48'h00_00_00_00_00_00, 0,  3, 8'h00, 0,  0,  0, 32'h0,         8'h00, 1, 16'h3F00);
        vecs[8] = mk(5, 48'h52_AA_BB_CC_DD_00, 0,  3, 8'h00, 1,  TMO, 0, 32'hAABB_CCDD, 8'h00, 1, 16'h5400);
        vecs[9] = mk(6, 48'h57_01_02_03_04_C3, 99, 3, 8'h00, TMO, TMO, 1, 32'h0102_0304, 8'hC3, 1, 16'h5400);

        // Clock/reset
        bus_idle_inputs();
        bus.rdata = 8'h00;
        rstn = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset values");
        rstn = 1'b1;
        step();

        // Table of complete commands
        for (int i = 0; i < NVEC; i++) run_txn(vecs[i], i);

        // Latency: stb one cycle after last byte; ack in accept cycle -> tx_valid 2 cycles later
        bus.rdata = 8'h77;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
        check("stb after last byte", {bus.cyc, bus.stb, bus.sel}, 64'h7);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("cyc drop after accept ack", {bus.cyc, bus.stb, tx_valid}, 64'h0);
        step();
        check("tx 2 cycles after ack", {tx_valid, tx_data}, {1'b1, ST_OK});
        recv_byte("lat status", ST_OK);
        recv_byte("lat data", 8'h77);

        // Timeout, then late ack/err with cyc low, then a normal write
        run_txn(vecs[8], 108);
        bad = 0;
        bus.ack = 1'b1;
        bus.err = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.cyc || tx_valid) bad = 1;
        end
        bus_idle_inputs();
        repeat (2) begin
            step();
            if (bus.cyc || tx_valid) bad = 1;
        end
        check("late ack ignored", 64'(bad), 64'd0);
        run_txn(vecs[0], 100);

        // Bad opcode with tx backpressure
        tx_ready = 1'b0;
        send_byte(8'h41);
        for (int k = 0; k < 10 && !tx_valid; k++) step();
        check("bp tx_valid raised", 64'(tx_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp hold %0d", c), {tx_valid, tx_data, rx_ready}, {1'b1, ST_BAD, 1'b0});
            step();
        end
        recv_byte("bp status", ST_BAD);
        check("bp tx_valid dropped", 64'(tx_valid), 64'd0);
        repeat (2) step();

        // Reset in the middle of a command
        send_byte(8'h57); send_byte(8'h30); send_byte(8'h00);
        rstn = 1'b0;
        step();
        check_reset_outputs("mid-command reset");
        rstn = 1'b1;
        step();
        run_txn(vecs[0], 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
